// File: rtl/wave_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wave_seq_pkg
//  Purpose  : Shared types and reset constants for the triangle-wave
//             sequencer (state encoding, default run configuration).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wave_seq_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;

    // Default configuration loaded at reset. The default peak is all-ones
    // at whatever WIDTH the controller is built with, so it is formed there.
    localparam int unsigned c_RST_STEP   = 1;
    localparam int unsigned c_RST_CYCLES = 0;

endpackage
`default_nettype wire

// File: rtl/wave_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
//  Module   : wave_step_unit
//  Purpose  : Combinational saturating step of the triangle sample.
//             Rising : wave+step clamped to peak (compare done in WIDTH+1
//                      bits so the sum never wraps).
//             Falling: wave-step clamped to 0.
//  Ports    : i_wave     current sample
//             i_step     step size
//             i_peak     clamp value while rising
//             i_down     1 = falling direction
//             o_wave_nxt next sample
//             o_hit      clamp reached (peak while rising, 0 while falling)
//  Revision : 1.0 - initial release
// ============================================================================
module wave_step_unit #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_wave,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_peak,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_wave_nxt,
    output logic             o_hit
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_wave} + {1'b0, i_step};

    always_comb begin
        o_hit      = 1'b0;
        o_wave_nxt = i_wave;
        if (i_down) begin
            o_hit      = (i_wave <= i_step);
            o_wave_nxt = o_hit ? '0 : (i_wave - i_step);
        end else begin
            o_hit      = (w_sum >= {1'b0, i_peak});
            o_wave_nxt = o_hit ? i_peak : w_sum[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wave_seq_ctrl
//  Purpose  : Programmable triangle-wave sequencer. Holds peak/step/cycle
//             configuration behind a valid/ready port (accepted in IDLE
//             only) and drives a saturating rise/fall triangle on 'wave'.
//  Ports    : clk, rst            clock, async active-high reset
//             cfg_valid/ready     configuration handshake
//             cfg_peak/step/cycles configuration word
//             cfg_err             1-cycle pulse, config rejected (zero field)
//             start, stop, pause  run control
//             wave                registered sample
//             falling, busy       state indicators
//             done                1-cycle pulse when a run ends
//  Revision : 1.0 - initial release
// ============================================================================
module wave_seq_ctrl
    import wave_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_peak,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_cycles,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [WIDTH-1:0] wave,
    output logic             falling,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_wave;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop_pend;
    logic             r_done;
    logic             r_cfg_err;
    logic [WIDTH-1:0] r_peak;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] r_cycles;

    logic [WIDTH-1:0] w_step_nxt;
    logic             w_step_hit;
    logic             w_cfg_acc;
    logic             w_cfg_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_run_end;

    wave_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_wave     (r_wave),
        .i_step     (r_step),
        .i_peak     (r_peak),
        .i_down     (r_state == ST_FALL),
        .o_wave_nxt (w_step_nxt),
        .o_hit      (w_step_hit)
    );

    assign w_cfg_acc = cfg_valid && (r_state == ST_IDLE);
    assign w_cfg_ok  = (cfg_peak != '0) && (cfg_step != '0);
    assign w_cnt_inc = r_cnt + 1'b1;
    // Continuous mode (cycles==0) never ends on count; the counter just wraps.
    assign w_run_end = r_stop_pend || ((r_cycles != '0) && (w_cnt_inc == r_cycles));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RISE;
                end
            end
            ST_RISE: begin
                if (!pause && w_step_hit) begin
                    w_state_nxt = ST_FALL;
                end
            end
            ST_FALL: begin
                if (!pause && w_step_hit) begin
                    w_state_nxt = w_run_end ? ST_IDLE : ST_RISE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        cfg_ready = (r_state == ST_IDLE);
        busy      = (r_state == ST_RISE) || (r_state == ST_FALL);
        falling   = (r_state == ST_FALL);
    end

    // ---------------- datapath, counter, config ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wave      <= '0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_peak      <= '1;
            r_step      <= WIDTH'(c_RST_STEP);
            r_cycles    <= CNT_W'(c_RST_CYCLES);
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            // Config lands on the same edge as a start, so it governs that run.
            if (w_cfg_acc) begin
                if (w_cfg_ok) begin
                    r_peak   <= cfg_peak;
                    r_step   <= cfg_step;
                    r_cycles <= cfg_cycles;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    // A stop presented alongside start is dropped here.
                    if (start) begin
                        r_wave      <= '0;
                        r_cnt       <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                ST_RISE, ST_FALL: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (!pause) begin
                        r_wave <= w_step_nxt;
                        if ((r_state == ST_FALL) && w_step_hit) begin
                            r_cnt <= w_cnt_inc;
                            if (w_run_end) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wave    = r_wave;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_seq_ctrl
//  Purpose  : Directed self-checking bench for wave_seq_ctrl. Inputs change
//             on the falling clock edge; outputs are sampled there too, i.e.
//             half a cycle after the rising edge that produced them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wave_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_peak;
    logic [4:0] cfg_step;
    logic [7:0] cfg_cycles;
    logic       cfg_err;
    logic       start;
    logic       stop;
    logic       pause;
    logic [4:0] wave;
    logic       falling;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    wave_seq_ctrl #(
        .WIDTH (5),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_peak   (cfg_peak),
        .cfg_step   (cfg_step),
        .cfg_cycles (cfg_cycles),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .wave       (wave),
        .falling    (falling),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a config word (optionally with start) for one cycle.
    task automatic drive_cfg(input int pk, input int st, input int cy, input bit with_start);
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_peak   = 5'(pk);
        cfg_step   = 5'(st);
        cfg_cycles = 8'(cy);
        start      = with_start;
        @(negedge clk);
        cfg_valid  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_valid = 0; cfg_peak = 0; cfg_step = 0; cfg_cycles = 0;
        start = 0; stop = 0; pause = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wave, busy, falling, done, cfg_err, cfg_ready} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state wave=%0d busy=%0b fall=%0b done=%0b err=%0b rdy=%0b expected 0,0,0,0,0,1",
                     wave, busy, falling, done, cfg_err, cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // peak 31, step 1, one triangle: 0..30 rising, 31..1 falling, then 0+done.
    task automatic test_full_triangle;
        int ew; bit ef; bit eb; bit ed; int busy_cnt;
        busy_cnt = 0;
        drive_cfg(31, 1, 1, 1'b1);
        for (int i = 0; i < 63; i++) begin
            if (i > 0) @(negedge clk);
            if (i <= 30)      begin ew = i;      ef = 0; eb = 1; ed = 0; end
            else if (i <= 61) begin ew = 62 - i; ef = 1; eb = 1; ed = 0; end
            else              begin ew = 0;      ef = 0; eb = 0; ed = 1; end
            if (busy) busy_cnt++;
            checks++;
            if ({wave, falling, busy, done} !== {5'(ew), ef, eb, ed}) begin
                failures++;
                $display("FAIL t1_sample[%0d] wave=%0d fall=%0b busy=%0b done=%0b expected %0d,%0b,%0b,%0b",
                         i, wave, falling, busy, done, ew, ef, eb, ed);
            end
        end
        checks++;
        if (busy_cnt !== 62) begin
            failures++;
            $display("FAIL t1_busy_len got=%0d expected=62", busy_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL t1_done_width done=%0b expected=0", done);
        end
    endtask

    // peak 10, step 3, two triangles: clamps at 10 and at 0.
    task automatic test_clamp;
        int ew[16] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3, 6, 9, 10, 7, 4, 1};
        bit ef[16] = '{0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 1,  1, 1, 1};
        drive_cfg(10, 3, 2, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, falling, busy, done} !== {5'(ew[i]), ef[i], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL t2_sample[%0d] wave=%0d fall=%0b busy=%0b done=%0b expected %0d,%0b,1,0",
                         i, wave, falling, busy, done, ew[i], ef[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({wave, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL t2_end wave=%0d busy=%0b done=%0b expected 0,0,1", wave, busy, done);
        end
    endtask

    task automatic test_cfg;
        bit seen;
        int ew[4] = '{0, 2, 4, 2};
        bit ef[4] = '{0, 0, 1, 1};
        // Rejected: peak == 0.
        @(negedge clk);
        cfg_valid = 1; cfg_peak = 0; cfg_step = 5; cfg_cycles = 3;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_ready_idle rdy=%0b expected=1", cfg_ready);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL t3_err_peak0 err=%0b expected=1", cfg_err);
        end
        // Rejected: step == 0.
        cfg_peak = 4; cfg_step = 0;
        @(negedge clk);
        cfg_valid = 0;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL t3_err_step0 err=%0b expected=1", cfg_err);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL t3_err_width err=%0b expected=0", cfg_err);
        end
        // Previous config (peak 10, step 3) must still be in force.
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (wave !== 5'd0) begin failures++; $display("FAIL t3_kept_s0 wave=%0d expected=0", wave); end
        @(negedge clk);
        checks++;
        if (wave !== 5'd3) begin failures++; $display("FAIL t3_kept_s1 wave=%0d expected=3", wave); end
        @(negedge clk);
        checks++;
        if (wave !== 5'd6) begin failures++; $display("FAIL t3_kept_s2 wave=%0d expected=6", wave); end
        // Config offered while busy must be refused.
        cfg_valid = 1; cfg_peak = 4; cfg_step = 2; cfg_cycles = 1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL t3_ready_busy rdy=%0b expected=0", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 0;
        checks++;
        if ({wave, cfg_err} !== {5'd9, 1'b0}) begin
            failures++;
            $display("FAIL t3_busy_noupd wave=%0d err=%0b expected 9,0", wave, cfg_err);
        end
        @(negedge clk);
        checks++;
        if ({wave, falling} !== {5'd10, 1'b1}) begin
            failures++;
            $display("FAIL t3_busy_peak wave=%0d fall=%0b expected 10,1", wave, falling);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL t3_done_timeout done=0 expected=1"); end
        // Config and start in the same cycle.
        drive_cfg(4, 2, 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, falling, busy} !== {5'(ew[i]), ef[i], 1'b1}) begin
                failures++;
                $display("FAIL t3_same_cycle[%0d] wave=%0d fall=%0b busy=%0b expected %0d,%0b,1",
                         i, wave, falling, busy, ew[i], ef[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({wave, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL t3_same_end wave=%0d busy=%0b done=%0b expected 0,0,1", wave, busy, done);
        end
    endtask

    task automatic test_stop;
        int ew[11] = '{0, 4, 8, 4, 0, 4, 8, 4, 0, 4, 8};
        bit ef[11] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        drive_cfg(8, 4, 0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, falling, busy} !== {5'(ew[i]), ef[i], 1'b1}) begin
                failures++;
                $display("FAIL t4_cont[%0d] wave=%0d fall=%0b busy=%0b expected %0d,%0b,1",
                         i, wave, falling, busy, ew[i], ef[i]);
            end
        end
        stop = 1;
        @(negedge clk);
        stop = 0;
        checks++;
        if ({wave, falling, busy, done} !== {5'd4, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL t4_stop_fall wave=%0d fall=%0b busy=%0b done=%0b expected 4,1,1,0",
                     wave, falling, busy, done);
        end
        @(negedge clk);
        checks++;
        if ({wave, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL t4_stop_end wave=%0d busy=%0b done=%0b expected 0,0,1", wave, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wave, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL t4_idle[%0d] wave=%0d busy=%0b done=%0b expected 0,0,0", i, wave, busy, done);
            end
        end
        // start and stop together in IDLE: the run must not end after one triangle.
        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, falling, busy} !== {5'(ew[i]), ef[i], 1'b1}) begin
                failures++;
                $display("FAIL t4_startstop[%0d] wave=%0d fall=%0b busy=%0b expected %0d,%0b,1",
                         i, wave, falling, busy, ew[i], ef[i]);
            end
        end
        stop = 1;
        @(negedge clk);
        stop = 0;
        checks++;
        if ({wave, falling} !== {5'd8, 1'b1}) begin
            failures++;
            $display("FAIL t4_stop2_peak wave=%0d fall=%0b expected 8,1", wave, falling);
        end
        @(negedge clk);
        checks++;
        if ({wave, busy} !== {5'd4, 1'b1}) begin
            failures++;
            $display("FAIL t4_stop2_fall wave=%0d busy=%0b expected 4,1", wave, busy);
        end
        @(negedge clk);
        checks++;
        if ({wave, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL t4_stop2_end wave=%0d busy=%0b done=%0b expected 0,0,1", wave, busy, done);
        end
    endtask

    task automatic test_pause;
        bit seen;
        drive_cfg(20, 1, 1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, busy} !== {5'(i), 1'b1}) begin
                failures++;
                $display("FAIL t5_rise[%0d] wave=%0d busy=%0b expected %0d,1", i, wave, busy, i);
            end
        end
        pause = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({wave, busy, falling} !== {5'd6, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL t5_hold[%0d] wave=%0d busy=%0b fall=%0b expected 6,1,0", k, wave, busy, falling);
            end
        end
        pause = 0;
        @(negedge clk);
        checks++;
        if (wave !== 5'd7) begin failures++; $display("FAIL t5_resume wave=%0d expected=7", wave); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL t5_done_timeout done=0 expected=1"); end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        int ew[6] = '{0, 2, 4, 6, 8, 6};
        drive_cfg(8, 2, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (wave !== 5'(ew[i])) begin
                failures++;
                $display("FAIL t6_pre[%0d] wave=%0d expected=%0d", i, wave, ew[i]);
            end
        end
        #1 rst = 1;
        #1;
        checks++;
        if ({wave, busy, falling, done} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL t6_async wave=%0d busy=%0b fall=%0b done=%0b expected 0,0,0,0",
                     wave, busy, falling, done);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({wave, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL t6_after[%0d] wave=%0d busy=%0b done=%0b expected 0,0,0", i, wave, busy, done);
            end
        end
        // Restart with the reset configuration: peak 31, step 1, continuous.
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({wave, busy} !== {5'(i), 1'b1}) begin
                failures++;
                $display("FAIL t6_restart[%0d] wave=%0d busy=%0b expected %0d,1", i, wave, busy, i);
            end
        end
        stop = 1;
        @(negedge clk);
        stop = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen || wave !== 5'd0) begin
            failures++;
            $display("FAIL t6_stop_end seen=%0b wave=%0d expected 1,0", seen, wave);
        end
    endtask

    initial begin
        test_reset();
        test_full_triangle();
        test_clamp();
        test_cfg();
        test_stop();
        test_pause();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
